// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry and draw-FSM encoding.
// Both the rectangle-fill stage and the scan-out stage import this package.
package fb_pkg;

   localparam int unsigned FB_WIDTH     = 400;
   localparam int unsigned FB_HEIGHT    = 300;
   localparam int unsigned X_BITS       = 9;
   localparam int unsigned Y_BITS       = 9;
   localparam int unsigned ADDR_BITS    = 17;
   localparam int unsigned CHANNEL_BITS = 2;
   localparam int unsigned COLOR_BITS   = 3 * CHANNEL_BITS;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StRow,
      StDone
   } fb_state_e;

endpackage

// File: rtl/fb_byte_mask.sv
// Works out how many pixels fit in the current 32-bit word and the matching byte enables.
// n = min(4 - b, remaining); we has bits b .. b+n-1 set.
module fb_byte_mask
   import fb_pkg::*;
(
   input  logic [1:0]      b,
   input  logic [X_BITS:0] remaining,
   output logic [2:0]      n,
   output logic [3:0]      we
);

   logic [2:0] avail;
   logic [3:0] ones;

   always_comb begin
      avail = 3'd4 - {1'b0, b};
      if (remaining < {{(X_BITS - 2){1'b0}}, avail}) begin
         n = remaining[2:0];
      end else begin
         n = avail;
      end
      unique case (n)
         3'd0:    ones = 4'b0000;
         3'd1:    ones = 4'b0001;
         3'd2:    ones = 4'b0011;
         3'd3:    ones = 4'b0111;
         default: ones = 4'b1111;
      endcase
      we = ones << b;
   end

endmodule

// File: rtl/fb_rect_fill.sv
// Solid rectangle fill into the downscaled frame buffer, up to four pixels per write,
// clipped to the buffer bounds. Write-port outputs are registered.
module fb_rect_fill
   import fb_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [X_BITS-1:0]     cmd_x0,
   input  logic [Y_BITS-1:0]     cmd_y0,
   input  logic [X_BITS-1:0]     cmd_x1,
   input  logic [Y_BITS-1:0]     cmd_y1,
   input  logic [COLOR_BITS-1:0] cmd_color,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           buffer_addr,
   output logic [31:0]           buffer_din,
   output logic                  buffer_en,
   output logic                  buffer_rst,
   output logic [3:0]            buffer_we
);

   localparam logic [X_BITS-1:0]    X_MAX      = X_BITS'(FB_WIDTH - 1);
   localparam logic [Y_BITS-1:0]    Y_MAX      = Y_BITS'(FB_HEIGHT - 1);
   localparam logic [ADDR_BITS-1:0] ROW_STRIDE = ADDR_BITS'(FB_WIDTH);

   fb_state_e              state_q;
   logic [X_BITS-1:0]      x0_q, x1_q, x_cur_q;
   logic [Y_BITS-1:0]      y0_q, y1_q, y_cur_q;
   logic [COLOR_BITS-1:0]  color_q;
   logic [ADDR_BITS-1:0]   row_base_q;
   logic                   last_q;

   logic [X_BITS-1:0]      x1c, x_sel;
   logic [Y_BITS-1:0]      y1c, y_sel;
   logic                   empty, setup, issue, row_end, last;
   logic [ADDR_BITS-1:0]   base, addr;
   logic [X_BITS:0]        remaining, x_next;
   logic [2:0]             n;
   logic [3:0]             we;
   logic [7:0]             pixel;

   assign buffer_rst = 1'b0;
   assign cmd_ready  = (state_q == StIdle) & ~rst;

   assign x1c   = (x1_q > X_MAX) ? X_MAX : x1_q;
   assign y1c   = (y1_q > Y_MAX) ? Y_MAX : y1_q;
   assign empty = (x0_q > x1c) | (y0_q > y1c) | (x0_q > X_MAX) | (y0_q > Y_MAX);

   // SETUP issues the first write itself so it is visible in the very next cycle.
   assign setup = (state_q == StSetup);
   assign issue = (setup & ~empty) | ((state_q == StRow) & ~last_q);
   assign base  = setup ? ADDR_BITS'(y0_q) * ROW_STRIDE : row_base_q;
   assign x_sel = setup ? x0_q : x_cur_q;
   assign y_sel = setup ? y0_q : y_cur_q;
   assign addr  = base + ADDR_BITS'(x_sel);

   assign remaining = {1'b0, x1c} - {1'b0, x_sel} + (X_BITS + 1)'(1);
   assign x_next    = {1'b0, x_sel} + (X_BITS + 1)'(n);
   assign row_end   = x_next > {1'b0, x1c};
   assign last      = row_end & (y_sel == y1c);
   assign pixel     = {{(8 - COLOR_BITS){1'b0}}, color_q};

   fb_byte_mask u_byte_mask (
      .b         (addr[1:0]),
      .remaining (remaining),
      .n         (n),
      .we        (we)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         x0_q        <= '0;
         x1_q        <= '0;
         x_cur_q     <= '0;
         y0_q        <= '0;
         y1_q        <= '0;
         y_cur_q     <= '0;
         color_q     <= '0;
         row_base_q  <= '0;
         last_q      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         buffer_addr <= '0;
         buffer_din  <= '0;
         buffer_en   <= 1'b0;
         buffer_we   <= '0;
      end else begin
         buffer_en <= 1'b0;
         buffer_we <= '0;
         done      <= 1'b0;

         if (issue) begin
            buffer_en   <= 1'b1;
            buffer_we   <= we;
            buffer_addr <= {{(32 - ADDR_BITS){1'b0}}, addr[ADDR_BITS-1:2], 2'b00};
            buffer_din  <= {4{pixel}};
            last_q      <= last;
            if (row_end) begin
               x_cur_q    <= x0_q;
               y_cur_q    <= y_sel + Y_BITS'(1);
               row_base_q <= base + ROW_STRIDE;
            end else begin
               x_cur_q    <= x_next[X_BITS-1:0];
               y_cur_q    <= y_sel;
               row_base_q <= base;
            end
         end

         unique case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  x0_q    <= cmd_x0;
                  y0_q    <= cmd_y0;
                  x1_q    <= cmd_x1;
                  y1_q    <= cmd_y1;
                  color_q <= cmd_color;
                  busy    <= 1'b1;
                  state_q <= StSetup;
               end
            end
            StSetup: begin
               if (empty) begin
                  done    <= 1'b1;
                  state_q <= StDone;
               end else begin
                  state_q <= StRow;
               end
            end
            StRow: begin
               // last_q marks that the write now on the port was the final one.
               if (last_q) begin
                  done    <= 1'b1;
                  state_q <= StDone;
               end
            end
            StDone: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Randomised and directed rectangle fills checked against a pixel-level model of the
// words each rectangle touches, plus write latency, done timing and reset behaviour.
module tb_fb_rect_fill;
   import fb_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  cmd_valid = 1'b0;
   logic                  cmd_ready;
   logic [X_BITS-1:0]     cmd_x0 = '0, cmd_x1 = '0;
   logic [Y_BITS-1:0]     cmd_y0 = '0, cmd_y1 = '0;
   logic [COLOR_BITS-1:0] cmd_color = '0;
   logic                  busy, done, buffer_en, buffer_rst;
   logic [31:0]           buffer_addr, buffer_din;
   logic [3:0]            buffer_we;

   int n_checks = 0;
   int n_errors = 0;

   int exp_addr[$];
   int exp_we[$];

   fb_rect_fill dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_x0      (cmd_x0),
      .cmd_y0      (cmd_y0),
      .cmd_x1      (cmd_x1),
      .cmd_y1      (cmd_y1),
      .cmd_color   (cmd_color),
      .busy        (busy),
      .done        (done),
      .buffer_addr (buffer_addr),
      .buffer_din  (buffer_din),
      .buffer_en   (buffer_en),
      .buffer_rst  (buffer_rst),
      .buffer_we   (buffer_we)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: walk every pixel of the clipped rectangle and group them into words.
   task automatic build_exp(input int x0, input int y0, input int x1, input int y1);
      int x1c, y1c, we;
      exp_addr.delete();
      exp_we.delete();
      x1c = (x1 > 399) ? 399 : x1;
      y1c = (y1 > 299) ? 299 : y1;
      if (x0 > x1c || y0 > y1c) return;
      for (int y = y0; y <= y1c; y++) begin
         for (int w = x0 / 4; w <= x1c / 4; w++) begin
            we = 0;
            for (int p = 0; p < 4; p++) begin
               if (w * 4 + p >= x0 && w * 4 + p <= x1c) we |= (1 << p);
            end
            exp_addr.push_back(y * 400 + w * 4);
            exp_we.push_back(we);
         end
      end
   endtask

   task automatic run_cmd(input string tag, input int x0, input int y0, input int x1,
                          input int y1, input int col, input bit hold_valid);
      int got_addr[$];
      int got_we[$];
      int cyc, first, done_cyc, bad, guard, nexp;
      logic [31:0] exp_din;
      x0 &= 511; y0 &= 511; x1 &= 511; y1 &= 511; col &= 63;
      build_exp(x0, y0, x1, y1);
      nexp = exp_addr.size();
      exp_din = {4{2'b00, col[5:0]}};
      guard = 0;
      while (!cmd_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      cmd_x0 = x0[8:0]; cmd_y0 = y0[8:0]; cmd_x1 = x1[8:0]; cmd_y1 = y1[8:0];
      cmd_color = col[5:0];
      cmd_valid = 1'b1;
      @(posedge clk);
      cyc = 0; first = -1; done_cyc = -1; bad = 0;
      while (done_cyc < 0 && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         if (!hold_valid) cmd_valid = 1'b0;
         if (buffer_en) begin
            if (first < 0) first = cyc;
            if (cyc != first + got_addr.size()) bad++;
            if (buffer_din !== exp_din) bad++;
            got_addr.push_back(int'(buffer_addr));
            got_we.push_back(int'(buffer_we));
         end
         if (done) begin
            done_cyc = cyc;
            cmd_valid = 1'b0;
         end
      end
      check({tag, "_nwrites"}, got_addr.size(), nexp);
      check({tag, "_done_cyc"}, done_cyc, nexp + 2);
      if (nexp > 0) check({tag, "_first_cyc"}, first, 2);
      for (int i = 0; i < got_addr.size() && i < nexp; i++) begin
         if (nexp <= 24) begin
            check($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
            check($sformatf("%s_we%0d", tag, i), got_we[i], exp_we[i]);
         end else if (got_addr[i] != exp_addr[i] || got_we[i] != exp_we[i]) begin
            bad++;
         end
      end
      check({tag, "_bad"}, bad, 0);
      @(negedge clk);
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_idle_ready"}, cmd_ready, 1);
      @(negedge clk);
      check({tag, "_no_reaccept"}, {busy, buffer_en}, 2'b00);
   endtask

   initial begin
      int wr, guard, x0, y0;

      // Reset
      repeat (3) @(negedge clk);
      check("rst_ready", cmd_ready, 0);
      check("rst_outs", {busy, done, buffer_en, buffer_rst, buffer_we}, 0);
      check("rst_addr", buffer_addr, 0);
      check("rst_din", buffer_din, 0);
      rst = 1'b0;
      #1;
      check("rel_ready", cmd_ready, 1);
      @(negedge clk);
      check("rel_outs", {busy, done, buffer_en, buffer_we}, 0);

      // Directed
      run_cmd("pixel", 5, 2, 5, 2, 'h2A, 1'b1);
      run_cmd("span", 2, 0, 9, 0, 'h15, 1'b1);
      run_cmd("clip", 396, 298, 1000, 1000, 'h3F, 1'b1);
      run_cmd("empty_x", 10, 0, 5, 0, 'h01, 1'b1);
      run_cmd("empty_w", 400, 0, 405, 0, 'h02, 1'b1);
      run_cmd("empty_h", 0, 300, 10, 305, 'h03, 1'b0);
      run_cmd("full", 0, 0, 399, 299, 'h3C, 1'b0);

      // Random
      for (int i = 0; i < 25; i++) begin
         x0 = $urandom_range(0, 415);
         y0 = $urandom_range(0, 305);
         run_cmd($sformatf("rnd%0d", i), x0, y0, $urandom_range(0, 511),
                 y0 + $urandom_range(0, 4) - 1, $urandom_range(0, 63), 1'($urandom_range(0, 1)));
      end

      // Reset during the third write of a full-screen fill
      while (!cmd_ready) @(negedge clk);
      cmd_x0 = 0; cmd_y0 = 0; cmd_x1 = 399; cmd_y1 = 299; cmd_color = 6'h11;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      wr = 0; guard = 0;
      while (wr < 3 && guard < 20) begin
         @(negedge clk);
         guard++;
         if (buffer_en) wr++;
      end
      check("mid_reached", wr, 3);
      rst = 1'b1;
      #1;
      check("mid_rst_we", buffer_we, 0);
      check("mid_rst_busy", {busy, buffer_en, done}, 0);
      @(negedge clk);
      rst = 1'b0;
      wr = 0;
      repeat (4) begin
         @(negedge clk);
         if (buffer_en) wr++;
      end
      check("mid_no_writes", wr, 0);
      run_cmd("post_rst", 5, 2, 5, 2, 'h2A, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fb_rect_fill.md
Name: fb_rect_fill

Overview:
- Upstream drawing stage of the GPU. Takes rectangle-fill commands and writes the solid colour into the downscaled frame buffer (FB_WIDTH x FB_HEIGHT, one byte per pixel, 32-bit words) through the frame buffer's write port.
- The scan-out stage reads the same buffer on the other port.
- Writes up to 4 horizontally adjacent pixels per cycle using byte enables. Clips commands to the buffer bounds.

Parameters:
- FB_WIDTH, 400, buffer pixels per row; must be a multiple of 4.
- FB_HEIGHT, 300, buffer rows.
- X_BITS, 9, width of x coordinates.
- Y_BITS, 9, width of y coordinates.
- ADDR_BITS, 17, width of the internal byte address.
- CHANNEL_BITS, 2, bits per colour channel; the pixel colour is 3*CHANNEL_BITS wide.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle, can accept a command.
- cmd_x0  in  X_BITS  left column, inclusive.
- cmd_y0  in  Y_BITS  top row, inclusive.
- cmd_x1  in  X_BITS  right column, inclusive.
- cmd_y1  in  Y_BITS  bottom row, inclusive.
- cmd_color  in  3*CHANNEL_BITS  fill colour.
- busy  out  1  high from accept until the done pulse, inclusive.
- done  out  1  one-cycle pulse when a command completes.
- buffer_addr  out  32  word-aligned byte address.
- buffer_din  out  32  write data.
- buffer_en  out  1  port enable.
- buffer_rst  out  1  tied 0.
- buffer_we  out  4  byte write enables.

Behaviour:
- Reset values (async, rst=1): state IDLE; cmd_ready=0 while rst is high, 1 in the first IDLE cycle after; busy=0, done=0, buffer_addr=0, buffer_din=0, buffer_en=0, buffer_we=0. Reset mid-command abandons the command immediately, with no further writes. Words already written stay written.
- Handshake: accept when cmd_valid && cmd_ready. cmd_ready=1 only in IDLE. Command fields are latched on accept. cmd_valid is ignored in all other states.
- FSM states: IDLE -> SETUP -> ROW -> DONE -> IDLE.
- SETUP (1 cycle):
  - Clamp x1 to min(x1, FB_WIDTH-1) and y1 to min(y1, FB_HEIGHT-1).
  - The command is empty if x0>x1c, y0>y1c, x0>=FB_WIDTH or y0>=FB_HEIGHT. An empty command goes to DONE with no writes.
  - Otherwise compute row_base = y0*FB_WIDTH, with x_cur=x0 and y_cur=y0.
- ROW, one write per cycle:
  - a = row_base + x_cur; b = a[1:0].
  - n = min(4-b, x1c-x_cur+1).
  - buffer_addr = {a[ADDR_BITS-1:2], 2'b00}, zero-extended to 32 bits.
  - buffer_we bits b..b+n-1 set.
  - buffer_din = {2'b0 pad, color} replicated in all 4 bytes.
  - buffer_en=1.
- ROW advance:
  - If x_cur+n > x1c, the row is finished. If y_cur==y1c, go to DONE. Otherwise y_cur+1, row_base += FB_WIDTH, x_cur = x0.
  - Otherwise x_cur += n.
- Write outputs are registered: the write for a given x_cur appears on the cycle after the decision. buffer_en=0 and buffer_we=0 in every non-write cycle.
- DONE (1 cycle): done=1, busy=1. Next cycle IDLE with cmd_ready=1.
- Latency:
  - Accept at cycle 0, SETUP at cycle 1, first write visible at cycle 2.
  - Writes per row = number of 32-bit words the span touches.
  - done is asserted the cycle after the last write's cycle.
  - For an empty command, done is at cycle 2.
- Arithmetic:
  - row_base is accumulated by adding FB_WIDTH per row; no multiplier in ROW. The SETUP multiply may be a single combinational product.
  - All address math is in ADDR_BITS bits; maximum address FB_WIDTH*FB_HEIGHT-1 < 2^ADDR_BITS.
- Because FB_WIDTH%4==0, each row starts word-aligned relative to row_base. Partial words occur only at span ends.

Decomposition:
- Shared package fb_pkg: FB_WIDTH, FB_HEIGHT, X_BITS, Y_BITS, ADDR_BITS, CHANNEL_BITS, derived COLOR_BITS, and the FSM state encoding. The scan-out side uses the same package.
- One combinational sub-module, fb_byte_mask: inputs b[1:0] and remaining-pixel count; outputs n[2:0] and we[3:0]. Unit-testable on its own.

Test Plan:
- Reset check: rst high for 3 cycles then released -> all outputs 0. cmd_ready=1 on the first cycle after release.
- Single pixel: x0=x1=5, y0=y1=2, color 6'h2A -> exactly one write: addr=804, we=4'b0010, din=32'h2A2A2A2A, at cycle 2. done at cycle 3.
- Unaligned span: x0=2, x1=9, y=0, color 6'h15 -> three consecutive writes:
  - addr 0, we 1100
  - addr 4, we 1111
  - addr 8, we 0011
  - then done.
- Clipping: x0=396, y0=298, x1=1000, y1=1000 -> two writes: addr 119596 and addr 119996, both we 1111, then done.
- Empty command: x0=10, x1=5 -> zero writes, done at cycle 2. Also x0=400 -> zero writes. cmd_valid held high during busy is not accepted twice.
- Reset mid-operation: full-screen fill (0,0,399,299), rst asserted during the 3rd write -> buffer_we=0 and busy=0 asynchronously. After release, a new single-pixel command completes correctly. A full fill issues exactly 30000 writes, all with we 1111.
